// File: rtl/pc_predict_if.sv
// Fetch-side bus for pc_predict.
//   master : the surrounding pipeline. It drives the fetch control, the redirect
//            request and the branch-resolution training inputs, and it observes
//            the fetch address and the prediction.
//   slave  : pc_predict itself.
// Signals:
//   pc_en, redirect, redirect_pc                 fetch control / flush
//   upd_valid, upd_pc, upd_taken, upd_target     resolved-branch training
//   iaddr, btb_hit, pred_taken, pred_target      fetch address + prediction
//   mispred_cnt                                  saturating redirect counter
interface pc_predict_if;
  logic        pc_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] iaddr;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] mispred_cnt;

  modport master (
    output pc_en, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  iaddr, btb_hit, pred_taken, pred_target, mispred_cnt
  );

  modport slave (
    input  pc_en, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output iaddr, btb_hit, pred_taken, pred_target, mispred_cnt
  );
endinterface

// File: rtl/pc_predict.sv
// pc_predict: fetch-stage PC with a direct-mapped BTB and per-entry saturating
// direction counters.
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   pc_predict_if.slave
//           in : pc_en, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target
//           out: iaddr (registered), btb_hit / pred_taken / pred_target
//                (combinational lookup of iaddr), mispred_cnt
// Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
// Lookups read the pre-edge BTB contents; no bypass from the same-cycle update.

// One BTB entry: holds valid/tag/target/ctr and applies training when selected.
module pc_predict_btb_entry #(
  parameter int TAG_W    = 26,
  parameter int CTR_BITS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                upd_en_i,     // upd_valid and index selects this entry
  input  logic [TAG_W-1:0]    upd_tag_i,
  input  logic                upd_taken_i,
  input  logic [31:0]         upd_target_i,
  output logic                valid_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [31:0]         target_o,
  output logic [CTR_BITS-1:0] ctr_o
);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  // Newly allocated entries start weakly taken; reset leaves them weakly not-taken.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS-1));
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'((1 << (CTR_BITS-1)) - 1);

  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [31:0]         target_q, target_d;
  logic [CTR_BITS-1:0] ctr_q, ctr_d;
  logic                hit;

  assign hit = valid_q && (tag_q == upd_tag_i);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_en_i) begin
      if (hit) begin
        if (upd_taken_i) begin
          if (ctr_q != CTR_MAX) ctr_d = ctr_q + CTR_ONE;
          target_d = upd_target_i;
        end else if (ctr_q != '0) begin
          ctr_d = ctr_q - CTR_ONE;
        end
      end else if (upd_taken_i) begin
        // Miss and taken: allocate, replacing any aliasing entry.
        valid_d  = 1'b1;
        tag_d    = upd_tag_i;
        target_d = upd_target_i;
        ctr_d    = CTR_WT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= CTR_RST;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign target_o = target_q;
  assign ctr_o    = ctr_q;
endmodule

module pc_predict #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          CTR_BITS    = 2
) (
  input logic         CLK,
  input logic         nRST,
  pc_predict_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [BTB_ENTRIES-1:0]               ent_vld;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]    ent_tag;
  logic [BTB_ENTRIES-1:0][31:0]         ent_tgt;
  logic [BTB_ENTRIES-1:0][CTR_BITS-1:0] ent_ctr;

  logic [31:0]      iaddr_q, iaddr_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      seq_pc;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             hit, ptaken;
  logic [31:0]      ptarget;
  logic             unused_upd_lsb;

  assign lk_idx = iaddr_q[IDX_W+1:2];
  assign lk_tag = iaddr_q[31:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[31:IDX_W+2];
  // Byte offset of the trained address carries no information.
  assign unused_upd_lsb = ^bus.upd_pc[1:0];

  generate
    for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_ent
      pc_predict_btb_entry #(
        .TAG_W    (TAG_W),
        .CTR_BITS (CTR_BITS)
      ) u_ent (
        .CLK          (CLK),
        .nRST         (nRST),
        .upd_en_i     (bus.upd_valid && (up_idx == IDX_W'(g))),
        .upd_tag_i    (up_tag),
        .upd_taken_i  (bus.upd_taken),
        .upd_target_i (bus.upd_target),
        .valid_o      (ent_vld[g]),
        .tag_o        (ent_tag[g]),
        .target_o     (ent_tgt[g]),
        .ctr_o        (ent_ctr[g])
      );
    end
  endgenerate

  // Zero-latency lookup on the registered fetch address.
  assign seq_pc  = iaddr_q + 32'd4;
  assign hit     = ent_vld[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign ptaken  = hit && ent_ctr[lk_idx][CTR_BITS-1];
  assign ptarget = hit ? ent_tgt[lk_idx] : seq_pc;

  // Redirect beats the stall: a flush must land even while fetch is held.
  always_comb begin
    iaddr_d = iaddr_q;
    if (bus.redirect)                iaddr_d = bus.redirect_pc;
    else if (bus.pc_en && ptaken)    iaddr_d = ptarget;
    else if (bus.pc_en)              iaddr_d = seq_pc;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.redirect && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iaddr_q <= PC_INIT;
      cnt_q   <= '0;
    end else begin
      iaddr_q <= iaddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.iaddr       = iaddr_q;
  assign bus.btb_hit     = hit;
  assign bus.pred_taken  = ptaken;
  assign bus.pred_target = ptarget;
  assign bus.mispred_cnt = cnt_q;
endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// array-based behavioural model, then a mid-cycle asynchronous reset.
module tb_pc_predict;
  localparam logic [31:0] PC_INIT = 32'h0000_0100;
  localparam int N  = 16;
  localparam int CB = 2;
  localparam int IW = 4;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  pc_predict_if bus();

  pc_predict #(
    .PC_INIT     (PC_INIT),
    .BTB_ENTRIES (N),
    .CTR_BITS    (CB)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) & 32'(N - 1));
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] a);
    return a >> (IW + 2);
  endfunction

  function automatic bit m_hit();
    int i = idx_of(m_pc);
    return m_v[i] && (m_tag[i] == tag_of(m_pc));
  endfunction

  function automatic bit m_pt();
    return m_hit() && (m_ctr[idx_of(m_pc)] >= 2**(CB-1));
  endfunction

  function automatic logic [31:0] m_ptgt();
    return m_hit() ? m_tgt[idx_of(m_pc)] : m_pc + 32'd4;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = PC_INIT;
    m_cnt = 32'd0;
    for (int i = 0; i < N; i++) begin
      m_v[i]   = 1'b0;
      m_tag[i] = 32'd0;
      m_tgt[i] = 32'd0;
      m_ctr[i] = 2**(CB-1) - 1;
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    logic [31:0] npc;
    int ui;
    bit uh;
    if (bus.redirect)                npc = bus.redirect_pc;
    else if (bus.pc_en && m_pt())    npc = m_ptgt();
    else if (bus.pc_en)              npc = m_pc + 32'd4;
    else                             npc = m_pc;
    if (bus.upd_valid) begin
      ui = idx_of(bus.upd_pc);
      uh = m_v[ui] && (m_tag[ui] == tag_of(bus.upd_pc));
      if (uh && bus.upd_taken) begin
        if (m_ctr[ui] < 2**CB - 1) m_ctr[ui] = m_ctr[ui] + 1;
        m_tgt[ui] = bus.upd_target;
      end else if (uh) begin
        if (m_ctr[ui] > 0) m_ctr[ui] = m_ctr[ui] - 1;
      end else if (bus.upd_taken) begin
        m_v[ui]   = 1'b1;
        m_tag[ui] = tag_of(bus.upd_pc);
        m_tgt[ui] = bus.upd_target;
        m_ctr[ui] = 2**(CB-1);
      end
    end
    if (bus.redirect && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
    m_pc = npc;
  endtask

  task automatic drive(bit en, bit red, logic [31:0] rpc,
                       bit uv, logic [31:0] upc, bit ut, logic [31:0] utg);
    bus.pc_en       = en;
    bus.redirect    = red;
    bus.redirect_pc = rpc;
    bus.upd_valid   = uv;
    bus.upd_pc      = upc;
    bus.upd_taken   = ut;
    bus.upd_target  = utg;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    model_step();
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // Single compare process: every mid-cycle, DUT outputs vs. model.
  always @(negedge CLK) begin
    if (check_en && nRST) begin
      chk("iaddr",       bus.iaddr,       m_pc);
      chk("btb_hit",     bus.btb_hit,     m_hit());
      chk("pred_taken",  bus.pred_taken,  m_pt());
      chk("pred_target", bus.pred_target, m_ptgt());
      chk("mispred_cnt", bus.mispred_cnt, m_cnt);
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_iaddr",  bus.iaddr,       32'h100);
    chk("rst_hit",    bus.btb_hit,     32'd0);
    chk("rst_pt",     bus.pred_taken,  32'd0);
    chk("rst_ptgt",   bus.pred_target, 32'h104);
    chk("rst_cnt",    bus.mispred_cnt, 32'd0);
    nRST = 1'b1;
    check_en = 1'b1;

    // Sequential fetch then stall
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("seq0", bus.iaddr, 32'h104);
    step(); chk("seq1", bus.iaddr, 32'h108);
    step(); chk("seq2", bus.iaddr, 32'h10C);
    chk("seq_nohit", bus.btb_hit, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); step(); chk("stall", bus.iaddr, 32'h10C);

    // Allocation and taken prediction
    drive(0, 0, 0, 1, 32'h110, 1, 32'h200);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("alloc_iaddr", bus.iaddr,       32'h110);
    chk("alloc_hit",   bus.btb_hit,     32'd1);
    chk("alloc_pt",    bus.pred_taken,  32'd1);
    chk("alloc_ptgt",  bus.pred_target, 32'h200);
    step(); chk("taken_jump", bus.iaddr, 32'h200);

    // Counter saturation at 0, then recovery
    drive(0, 0, 0, 1, 32'h110, 0, 0);
    step(); step(); step();
    drive(0, 1, 32'h110, 0, 0, 0, 0);
    step();
    chk("sat_hit", bus.btb_hit,     32'd1);
    chk("sat_pt",  bus.pred_taken,  32'd0);
    chk("sat_cnt", bus.mispred_cnt, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("sat_fall", bus.iaddr, 32'h114);
    drive(0, 0, 0, 1, 32'h110, 1, 32'h200);
    step();
    drive(0, 1, 32'h110, 0, 0, 0, 0);
    step(); chk("ctr1_pt", bus.pred_taken, 32'd0);
    drive(0, 0, 0, 1, 32'h110, 1, 32'h200);
    #1; chk("nobypass_pt", bus.pred_taken, 32'd0);
    step(); chk("ctr2_pt", bus.pred_taken, 32'd1);

    // Redirect beats stall and taken prediction
    drive(0, 1, 32'h300, 0, 0, 0, 0);
    step();
    chk("redir_iaddr", bus.iaddr,       32'h300);
    chk("redir_cnt",   bus.mispred_cnt, 32'd3);

    // Aliasing and same-index same-cycle update
    drive(0, 1, 32'h080, 1, 32'h040, 1, 32'h500);
    step(); chk("alias_hit", bus.btb_hit, 32'd0);
    drive(1, 0, 0, 1, 32'h080, 1, 32'h600);
    #1; chk("same_cyc_pt", bus.pred_taken, 32'd0);
    step(); chk("same_cyc_next", bus.iaddr, 32'h084);
    drive(0, 1, 32'h080, 0, 0, 0, 0);
    step();
    chk("alias2_hit",  bus.btb_hit,     32'd1);
    chk("alias2_pt",   bus.pred_taken,  32'd1);
    chk("alias2_ptgt", bus.pred_target, 32'h600);

    // Wrap-around
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step();
    chk("wrap_iaddr", bus.iaddr,       32'hFFFF_FFFC);
    chk("wrap_ptgt",  bus.pred_target, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("wrap_next", bus.iaddr, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, pick_addr(),
            $urandom_range(0, 1) == 1, pick_addr() | 32'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0, pick_addr());
      step();
    end

    // Mid-cycle asynchronous reset
    @(posedge CLK);
    #3;
    check_en = 1'b0;
    nRST = 1'b0;
    #1;
    chk("arst_iaddr", bus.iaddr,       32'h100);
    chk("arst_hit",   bus.btb_hit,     32'd0);
    chk("arst_pt",    bus.pred_taken,  32'd0);
    chk("arst_ptgt",  bus.pred_target, 32'h104);
    chk("arst_cnt",   bus.mispred_cnt, 32'd0);
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    chk("arst_hold", bus.iaddr, 32'h100);
    nRST = 1'b1;
    check_en = 1'b1;
    drive(0, 1, 32'h080, 0, 0, 0, 0);
    step();
    chk("arst_btb_clr", bus.btb_hit,     32'd0);
    chk("arst_cnt1",    bus.mispred_cnt, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("arst_adv", bus.iaddr, 32'h084);
    @(negedge CLK);
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got no summary expected completion");
    $fatal(1, "timeout");
  end
endmodule
